// File: rtl/weight_bank_sched.sv
// Weight-bank read scheduler: one LOAD strobe, one SETTLE cycle, then rd_len reads gated by wt_ready.
// Every output is registered; wt_valid trails mem_rdena by the bank's 1-cycle read latency.
module weight_bank_sched #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_DEPTH = 2048,
  parameter int MAX_LAYER  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [3:0]            layer_id_i,
  input  logic [ADDR_WIDTH:0]   rd_len_i,
  input  logic                  abort_i,
  input  logic                  wt_ready_i,
  output logic                  mem_csen_o,
  output logic                  mem_wrenb_o,
  output logic [3:0]            mem_layer_cnt_o,
  output logic                  mem_rdena_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  wt_valid_o,
  output logic                  wt_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [3:0]    MAX_L = 4'(MAX_LAYER);
  localparam logic [LW-1:0] DEPTH = LW'(DATA_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_READ   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            layer_q, layer_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic                  csen_q, csen_d;
  logic                  wrenb_q, wrenb_d;
  logic [3:0]            layer_cnt_q, layer_cnt_d;
  logic                  rdena_q, rdena_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  req_legal;

  assign req_legal = (layer_id_i != 4'd0) && (layer_id_i <= MAX_L) &&
                     (rd_len_i != '0) && (rd_len_i <= DEPTH);

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    csen_d      = 1'b0;
    wrenb_d     = 1'b0;
    layer_cnt_d = 4'd0;
    rdena_d     = 1'b0;
    addr_d      = addr_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Abort outranks everything; outputs fall back to their idle defaults.
    if (state_q != S_IDLE && abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_d = '0;
          if (start_i && !abort_i) begin
            if (req_legal) begin
              state_d     = S_LOAD;
              layer_d     = layer_id_i;
              len_d       = rd_len_i;
              cnt_d       = '0;
              csen_d      = 1'b1;
              wrenb_d     = 1'b1;
              layer_cnt_d = layer_id_i;
              busy_d      = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_d     = S_SETTLE;
          layer_cnt_d = layer_q;
          busy_d      = 1'b1;
        end
        S_SETTLE, S_READ: begin
          busy_d      = 1'b1;
          layer_cnt_d = layer_q;
          valid_d     = rdena_q;
          // cnt_q reaching len_q means the final address is on the bus this cycle.
          if (state_q == S_READ && cnt_q == len_q) begin
            state_d = S_DRAIN;
            last_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            addr_d  = cnt_q[ADDR_WIDTH-1:0];
            if (wt_ready_i) begin
              csen_d  = 1'b1;
              rdena_d = 1'b1;
              cnt_d   = cnt_q + LW'(1);
            end
          end
        end
        S_DRAIN: begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
        default: begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= 4'd0;
      len_q       <= '0;
      cnt_q       <= '0;
      csen_q      <= 1'b0;
      wrenb_q     <= 1'b0;
      layer_cnt_q <= 4'd0;
      rdena_q     <= 1'b0;
      addr_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      csen_q      <= csen_d;
      wrenb_q     <= wrenb_d;
      layer_cnt_q <= layer_cnt_d;
      rdena_q     <= rdena_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_csen_o      = csen_q;
  assign mem_wrenb_o     = wrenb_q;
  assign mem_layer_cnt_o = layer_cnt_q;
  assign mem_rdena_o     = rdena_q;
  assign mem_addr_o      = addr_q;
  assign wt_valid_o      = valid_q;
  assign wt_last_o       = last_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
